// File: rtl/invaders_pkg.sv
// Shared definitions for the invaders video game blocks.
//
// Contents:
//   screen_w, screen_h  visible raster size in pixels
//   gun_row             top row of the player's gun; the laser spawns just above it
//   laser_state_e       projectile engine states
//   gun_centre()        laser spawn column from the gun extents, clamped at column 0

package invaders_pkg;

    localparam int unsigned screen_w = 640;
    localparam int unsigned screen_h = 480;
    localparam int unsigned gun_row  = 389;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } laser_state_e;

    // Midpoint of the gun span minus half the laser width. The sum needs 11 bits so a gun
    // near column 1023 does not wrap; the subtraction saturates at 0 for a gun hugging the
    // left edge.
    function automatic logic [9:0] gun_centre(input logic [9:0] left,
                                              input logic [9:0] right,
                                              input logic [9:0] half_w);
        logic [9:0] mid;
        mid = 10'(({1'b0, left} + {1'b0, right}) >> 1);
        return (mid >= half_w) ? (mid - half_w) : 10'd0;
    endfunction

endpackage

// File: rtl/laser_ctrl_if.sv
// Signal bundle between the laser engine and its neighbours (player, enemy, paint mux).
//
// Inputs to the engine:  frame_i, fire_i, gun_left_i/gun_right_i, enemy box
//                        (enemy_left_i/right_i/top_i/bot_i), enemy_alive_i, raster x_i/y_i
// Outputs of the engine: active_o, laser_x_o/laser_y_o, hit_o, laser_area_o,
//                        red_o/green_o/blue_o
//
// Modports:
//   master  the surroundings: drive the inputs, observe the outputs
//   slave   the laser engine itself

interface laser_ctrl_if;

    logic       frame_i;
    logic       fire_i;
    logic [9:0] gun_left_i;
    logic [9:0] gun_right_i;
    logic [9:0] enemy_left_i;
    logic [9:0] enemy_right_i;
    logic [9:0] enemy_top_i;
    logic [9:0] enemy_bot_i;
    logic       enemy_alive_i;
    logic [9:0] x_i;
    logic [9:0] y_i;

    logic       active_o;
    logic [9:0] laser_x_o;
    logic [9:0] laser_y_o;
    logic       hit_o;
    logic       laser_area_o;
    logic [3:0] red_o;
    logic [3:0] green_o;
    logic [3:0] blue_o;

    modport master (
        output frame_i, fire_i, gun_left_i, gun_right_i,
        output enemy_left_i, enemy_right_i, enemy_top_i, enemy_bot_i, enemy_alive_i,
        output x_i, y_i,
        input  active_o, laser_x_o, laser_y_o, hit_o, laser_area_o,
        input  red_o, green_o, blue_o
    );

    modport slave (
        input  frame_i, fire_i, gun_left_i, gun_right_i,
        input  enemy_left_i, enemy_right_i, enemy_top_i, enemy_bot_i, enemy_alive_i,
        input  x_i, y_i,
        output active_o, laser_x_o, laser_y_o, hit_o, laser_area_o,
        output red_o, green_o, blue_o
    );

endinterface

// File: rtl/box_overlap.sv
// Combinational rectangle overlap test.
//
// Box A (the projectile) is w_p x h_p pixels with its top-left corner at (a_x, a_y); its
// bounds are inclusive. Box B (the target) is given by its edges, which are exclusive:
// only B's open interior counts as a hit. All arithmetic is 11-bit so A's right/bottom
// edge cannot wrap near coordinate 1023.
//
// Ports:
//   a_x, a_y                        top-left of box A
//   b_left, b_right, b_top, b_bot   edges of box B
//   overlap                         1 when A touches B's interior

module box_overlap #(
    parameter int unsigned w_p = 2,
    parameter int unsigned h_p = 12
) (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] b_left,
    input  logic [9:0] b_right,
    input  logic [9:0] b_top,
    input  logic [9:0] b_bot,
    output logic       overlap
);

    logic [10:0] a_left;
    logic [10:0] a_right;
    logic [10:0] a_top;
    logic [10:0] a_bot;

    assign a_left  = {1'b0, a_x};
    assign a_top   = {1'b0, a_y};
    assign a_right = a_left + 11'(w_p - 1);
    assign a_bot   = a_top + 11'(h_p - 1);

    assign overlap = (a_right > {1'b0, b_left}) && (a_left < {1'b0, b_right}) &&
                     (a_bot > {1'b0, b_top}) && (a_top < {1'b0, b_bot});

endmodule

// File: rtl/laser_ctrl.sv
// Player laser engine: spawns one laser above the gun on a fire request, moves it upward
// once per frame, checks it against the enemy box and retires it on a hit or at the top
// of the screen, followed by a cooldown before the next shot is accepted.
//
// Ports:
//   clk_i      pixel clock (25 MHz)
//   reset_n_i  synchronous active-low reset
//   bus        laser_ctrl_if.slave: frame/fire/gun/enemy/raster inputs; active, position,
//              one-cycle hit pulse, per-pixel draw flag and constant colour outputs

module laser_ctrl
    import invaders_pkg::*;
#(
    parameter int unsigned laser_w_p   = 2,
    parameter int unsigned laser_h_p   = 12,
    parameter int unsigned speed_p     = 6,
    parameter int unsigned spawn_y_p   = gun_row - laser_h_p,
    parameter int unsigned top_limit_p = 8,
    parameter int unsigned cooldown_p  = 15,
    parameter logic [11:0] color_p     = 12'hF00
) (
    input logic         clk_i,
    input logic         reset_n_i,
    laser_ctrl_if.slave bus
);

    localparam int unsigned cnt_w      = (cooldown_p > 0) ? $clog2(cooldown_p + 1) : 1;
    localparam logic [9:0]  half_w     = 10'(laser_w_p >> 1);
    // Below this row another step of speed_p would cross top_limit_p, so the laser retires.
    localparam logic [10:0] retire_row = 11'(top_limit_p + speed_p);

    laser_state_e     state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             collide;

    // Collision is judged on the position before this frame's move.
    box_overlap #(
        .w_p (laser_w_p),
        .h_p (laser_h_p)
    ) u_collide (
        .a_x     (x_q),
        .a_y     (y_q),
        .b_left  (bus.enemy_left_i),
        .b_right (bus.enemy_right_i),
        .b_top   (bus.enemy_top_i),
        .b_bot   (bus.enemy_bot_i),
        .overlap (collide)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.fire_i) begin
                    x_d     = gun_centre(bus.gun_left_i, bus.gun_right_i, half_w);
                    y_d     = 10'(spawn_y_p);
                    state_d = FLY;
                end
            end

            FLY: begin
                if (bus.frame_i) begin
                    if (bus.enemy_alive_i && collide) begin
                        hit_d   = 1'b1;
                        cnt_d   = cnt_w'(cooldown_p);
                        state_d = COOL;
                    end else if ({1'b0, y_q} < retire_row) begin
                        cnt_d   = cnt_w'(cooldown_p);
                        state_d = COOL;
                    end else begin
                        y_d = y_q - 10'(speed_p);
                    end
                end
            end

            COOL: begin
                // The zero test comes first so a zero cooldown spends exactly one cycle here.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else if (bus.frame_i) begin
                    cnt_d = cnt_q - cnt_w'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    // Draw flag: purely combinational on the raster position so it has no pixel latency.
    logic [10:0] px, py;
    logic [10:0] lx_lo, lx_hi, ly_lo, ly_hi;

    assign px    = {1'b0, bus.x_i};
    assign py    = {1'b0, bus.y_i};
    assign lx_lo = {1'b0, x_q};
    assign ly_lo = {1'b0, y_q};
    assign lx_hi = lx_lo + 11'(laser_w_p - 1);
    assign ly_hi = ly_lo + 11'(laser_h_p - 1);

    assign bus.active_o     = (state_q == FLY);
    assign bus.laser_x_o    = x_q;
    assign bus.laser_y_o    = y_q;
    assign bus.hit_o        = hit_q;
    assign bus.laser_area_o = (state_q == FLY) && (px >= lx_lo) && (px <= lx_hi) &&
                              (py >= ly_lo) && (py <= ly_hi);

    assign bus.red_o   = color_p[11:8];
    assign bus.green_o = color_p[7:4];
    assign bus.blue_o  = color_p[3:0];

endmodule

// File: tb/tb_laser_ctrl.sv
// Bench for laser_ctrl: directed shots followed by randomised shots, each predicted by a
// trajectory model computed from the flight rules with plain integer arithmetic.

module tb_laser_ctrl;

    localparam int W      = 2;
    localparam int H      = 12;
    localparam int SPEED  = 6;
    localparam int SPAWN  = 377;
    localparam int LIMIT  = 8;
    localparam int COOL_F = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    laser_ctrl_if intf ();

    laser_ctrl dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (intf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int act, input int x, input int y,
                           input int hit);
        chk({tag, "_active"}, 32'(intf.active_o), 32'(act));
        chk({tag, "_x"}, 32'(intf.laser_x_o), 32'(x));
        chk({tag, "_y"}, 32'(intf.laser_y_o), 32'(y));
        chk({tag, "_hit"}, 32'(intf.hit_o), 32'(hit));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trajectory model: frame f (1-based) looks at row SPAWN - SPEED*(f-1). Returns the
    // frame on which the flight ends and whether it ends in a hit.
    task automatic predict(input int lx, input int el, input int er, input int et,
                           input int eb, input bit alive, output int n, output bit hit);
        int y;
        n   = 0;
        hit = 1'b0;
        for (int f = 1; f < 200 && n == 0; f++) begin
            y = SPAWN - SPEED * (f - 1);
            if (alive && (lx + W - 1 > el) && (lx < er) && (y + H - 1 > et) && (y < eb)) begin
                n   = f;
                hit = 1'b1;
            end else if (y < LIMIT + SPEED) begin
                n = f;
            end
        end
    endtask

    // Walk a window around the laser and compare the draw flag with the rectangle.
    task automatic sweep(input string tag, input int lx, input int ly, input bit act);
        int cnt;
        bit exp_in;
        cnt = 0;
        for (int yy = ly - 3; yy <= ly + H + 2; yy++) begin
            for (int xx = lx - 3; xx <= lx + W + 2; xx++) begin
                intf.x_i = 10'(xx);
                intf.y_i = 10'(yy);
                #1;
                exp_in = act && (xx >= lx) && (xx < lx + W) && (yy >= ly) && (yy < ly + H);
                if (intf.laser_area_o === 1'b1) cnt++;
                chk(tag, 32'(intf.laser_area_o), 32'(exp_in));
            end
        end
        chk({tag, "_count"}, 32'(cnt), act ? 32'(W * H) : 32'd0);
    endtask

    // One complete shot: fire from IDLE, fly, end, cooldown, return to IDLE. A non-zero
    // rst_at pulses reset together with that frame and abandons the shot.
    task automatic shot(input int gl, input int gr, input int el, input int er, input int et,
                        input int eb, input bit alive, input bit hold, input int rst_at,
                        input int sweep_at);
        int lx, n, gaps;
        bit hit, aborted;
        lx = (gl + gr) / 2 - W / 2;
        if (lx < 0) lx = 0;
        predict(lx, el, er, et, eb, alive, n, hit);
        aborted = 1'b0;

        intf.gun_left_i    = 10'(gl);
        intf.gun_right_i   = 10'(gr);
        intf.enemy_left_i  = 10'(el);
        intf.enemy_right_i = 10'(er);
        intf.enemy_top_i   = 10'(et);
        intf.enemy_bot_i   = 10'(eb);
        intf.enemy_alive_i = alive;
        intf.fire_i        = 1'b1;
        tick();
        intf.fire_i = hold;
        chk_all("spawn", 1, lx, SPAWN, 0);

        for (int f = 1; f <= n && !aborted; f++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                if (!hold) intf.fire_i = 1'($urandom_range(0, 1));
                tick();
            end
            chk("gap_y", 32'(intf.laser_y_o), 32'(SPAWN - SPEED * (f - 1)));
            if (f == sweep_at) sweep("area_fly", lx, SPAWN - SPEED * (f - 1), 1'b1);
            intf.frame_i = 1'b1;
            if (f == rst_at) rst_n = 1'b0;
            tick();
            intf.frame_i = 1'b0;
            if (f == rst_at) begin
                chk_all("reset_mid", 0, 0, 0, 0);
                rst_n       = 1'b1;
                intf.fire_i = 1'b0;
                tick();
                chk_all("reset_after", 0, 0, 0, 0);
                aborted = 1'b1;
            end else if (f < n) begin
                chk_all("fly", 1, lx, SPAWN - SPEED * f, 0);
            end else begin
                chk_all("end", 0, lx, SPAWN - SPEED * (f - 1), int'(hit));
            end
        end

        if (!aborted) begin
            tick();
            chk("hit_width", 32'(intf.hit_o), 32'd0);
            if (sweep_at != 0) sweep("area_idle", lx, SPAWN - SPEED * (n - 1), 1'b0);
            for (int c = 1; c <= COOL_F; c++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    if (!hold) intf.fire_i = 1'($urandom_range(0, 1));
                    tick();
                end
                intf.frame_i = 1'b1;
                tick();
                intf.frame_i = 1'b0;
                chk("cool_active", 32'(intf.active_o), 32'd0);
                chk("cool_hit", 32'(intf.hit_o), 32'd0);
            end
            // Counter is now 0: this edge only returns to IDLE, so a fire here is ignored.
            intf.fire_i = hold ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            chk("cool_exit", 32'(intf.active_o), 32'd0);
            intf.fire_i = 1'b0;
        end
    endtask

    initial begin
        int gl, gr, ctr, el, er, et, eb, rst_at;
        bit alive, hold;

        intf.frame_i       = 1'b0;
        intf.fire_i        = 1'b0;
        intf.gun_left_i    = '0;
        intf.gun_right_i   = '0;
        intf.enemy_left_i  = '0;
        intf.enemy_right_i = '0;
        intf.enemy_top_i   = '0;
        intf.enemy_bot_i   = '0;
        intf.enemy_alive_i = 1'b0;
        intf.x_i           = '0;
        intf.y_i           = '0;

        rst_n = 1'b0;
        tick();
        intf.fire_i = 1'b1;
        tick();
        chk_all("reset", 0, 0, 0, 0);
        chk("color", 32'({intf.red_o, intf.green_o, intf.blue_o}), 32'h0F00);
        intf.fire_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_all("idle", 0, 0, 0, 0);

        // Directed shots.
        shot(300, 320, 0, 0, 0, 0, 1'b0, 1'b0, 0, 29);
        shot(300, 320, 290, 340, 100, 130, 1'b1, 1'b0, 0, 0);
        shot(300, 320, 290, 340, 100, 130, 1'b0, 1'b0, 0, 0);
        shot(300, 320, 290, 340, 100, 130, 1'b1, 1'b1, 0, 0);
        shot(0, 1, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        shot(1023, 1023, 1000, 1023, 100, 130, 1'b1, 1'b0, 0, 0);
        shot(300, 320, 290, 340, 100, 130, 1'b1, 1'b0, 43, 0);
        shot(300, 320, 290, 340, 100, 130, 1'b1, 1'b0, 5, 0);

        // Randomised shots.
        for (int s = 0; s < 12; s++) begin
            gl  = $urandom_range(0, 1000);
            gr  = gl + $urandom_range(0, 23);
            ctr = (gl + gr) / 2;
            el  = ctr - $urandom_range(0, 40);
            if (el < 0) el = 0;
            er  = el + $urandom_range(1, 80);
            if (er > 1023) er = 1023;
            et  = $urandom_range(0, 300);
            eb  = et + $urandom_range(1, 60);
            alive  = ($urandom_range(0, 3) != 0);
            hold   = 1'($urandom_range(0, 1));
            rst_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : 0;
            shot(gl, gr, el, er, et, eb, alive, hold, rst_at, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
